// File: rtl/crc_check.sv
// Serial LSB-first CRC receiver: runs the payload through an 8-bit LFSR, then compares the trailing CRC bits.
// Optional CRC_ERR_CNT_EN adds a saturating count of errored frames on err_count.
module crc_check #(
    parameter logic [7:0] SEED = 8'hD8,
    parameter logic [6:0] TAPS = 7'b1000100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       data_in,
    input  logic       data_valid,
    input  logic       crc_valid,
    output logic       busy,
    output logic       done,
    output logic       crc_err,
    output logic [7:0] err_count
);

    typedef enum logic [1:0] {IDLE, DATA, CRC} state_t;

    state_t     state;
    logic [7:0] lfsr;
    logic [3:0] cnt;
    logic       mismatch;

    logic [7:0] crc_ref;
    logic [7:0] data_base;
    logic [3:0] cnt_inc;
    logic       mis_nxt;
    logic       take_crc;
    logic       fin;

    function automatic logic [7:0] lfsr_step(input logic [7:0] l, input logic d);
        logic [7:0] n;
        logic       fb;
        fb = l[0] ^ d;
        for (int i = 0; i < 7; i++)
            n[i] = l[i+1] ^ (TAPS[i] & fb);
        n[7] = fb;
        return n;
    endfunction

    // A zero-length frame compares straight against SEED; otherwise against the running LFSR.
    always_comb begin
        crc_ref   = (state == IDLE) ? SEED : lfsr;
        data_base = (state == DATA) ? lfsr : SEED;
        cnt_inc   = (state == CRC) ? cnt + 4'd1 : 4'd1;
        mis_nxt   = ((state == CRC) ? mismatch : 1'b0) | (data_in != crc_ref[0]);
        take_crc  = crc_valid & ~data_valid;
        fin       = take_crc & (cnt_inc == 4'd8);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            lfsr     <= SEED;
            cnt      <= 4'd0;
            mismatch <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            crc_err  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (data_valid) begin
                // Also covers abort from CRC: restart from SEED without touching crc_err.
                state    <= DATA;
                busy     <= 1'b1;
                lfsr     <= lfsr_step(data_base, data_in);
                cnt      <= 4'd0;
                mismatch <= 1'b0;
            end else if (take_crc) begin
                lfsr <= {1'b0, crc_ref[7:1]};
                if (fin) begin
                    state    <= IDLE;
                    busy     <= 1'b0;
                    cnt      <= 4'd0;
                    mismatch <= 1'b0;
                    done     <= 1'b1;
                    crc_err  <= mis_nxt;
                end else begin
                    state    <= CRC;
                    busy     <= 1'b1;
                    cnt      <= cnt_inc;
                    mismatch <= mis_nxt;
                end
            end
        end
    end

`ifdef CRC_ERR_CNT_EN
    logic [7:0] err_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            err_cnt_q <= 8'h00;
        else if (fin && mis_nxt && err_cnt_q != 8'hFF)
            err_cnt_q <= err_cnt_q + 8'd1;
    end

    assign err_count = err_cnt_q;
`else
    assign err_count = 8'h00;
`endif

endmodule
